// File: rtl/mmio_uart_tx_if.sv
// CPU-side memory/IO bus bundle for the memory-mapped UART transmitter.
// The CPU drives address/data/strobe; the peripheral returns registered read data and hit.
interface mmio_uart_tx_if;
    logic [15:0] cpu_address;
    logic [15:0] cpu_write_data;
    logic        cpu_write_enable;
    logic [15:0] cpu_read_data;
    logic        cpu_read_hit;

    modport master (
        output cpu_address,
        output cpu_write_data,
        output cpu_write_enable,
        input  cpu_read_data,
        input  cpu_read_hit
    );

    modport slave (
        input  cpu_address,
        input  cpu_write_data,
        input  cpu_write_enable,
        output cpu_read_data,
        output cpu_read_hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: CPU byte writes go through a TX FIFO and
// are shifted out LSB-first; a status word is readable with one cycle of latency.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] DATA_ADDR    = 16'hFFFB,
    parameter logic [15:0] STATUS_ADDR  = 16'hFFFA
) (
    input  logic         clock,
    input  logic         reset,
    mmio_uart_tx_if.slave bus,
    output logic         tx,
    output logic         tx_busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------- bus decode ----------------
    logic push_req;
    logic status_wr;
    logic status_sel;

    assign push_req   = bus.cpu_write_enable && (bus.cpu_address == DATA_ADDR);
    assign status_wr  = bus.cpu_write_enable && (bus.cpu_address == STATUS_ADDR);
    assign status_sel = (bus.cpu_address == STATUS_ADDR);

    logic unused_wdata;
    assign unused_wdata = ^{bus.cpu_write_data[15:8], bus.cpu_write_data[2:0]};

    // ---------------- FIFO ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full, fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             overflow_q;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.cpu_write_data[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end else if (status_wr && bus.cpu_write_data[3]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ---------------- transmit FSM ----------------
    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        baud_last;

    assign baud_last = (baud_q == 16'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line and busy are registered from the state, so both trail the FSM by one cycle.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != S_IDLE);
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

    // ---------------- status read path ----------------
    logic [15:0] status;
    logic [15:0] rdata_q;
    logic        hit_q;

    assign status = {8'h00, 4'(count_q), overflow_q, busy_q, fifo_empty, fifo_full};

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            rdata_q <= status_sel ? status : 16'h0000;
            hit_q   <= status_sel;
        end
    end

    assign bus.cpu_read_data = rdata_q;
    assign bus.cpu_read_hit  = hit_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bus reads/writes in one sequence, a serial
// monitor decoding 8N1 frames against a queue of expected bytes.
module tb_mmio_uart_tx;

    logic clock = 1'b0;
    logic reset;
    logic tx;
    logic tx_busy;

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (8),
        .DATA_ADDR   (16'hFFFB),
        .STATUS_ADDR (16'hFFFA)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus_if),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] sb [$];
    int         gaps [$];
    int         frames_rx = 0;
    bit         mon_abort = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered and left at a negedge.
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        bus_if.cpu_address      = addr;
        bus_if.cpu_write_data   = data;
        bus_if.cpu_write_enable = 1'b1;
        @(negedge clock);
        bus_if.cpu_write_enable = 1'b0;
        bus_if.cpu_address      = 16'h0000;
        bus_if.cpu_write_data   = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] rd, output logic hit);
        bus_if.cpu_address      = addr;
        bus_if.cpu_write_enable = 1'b0;
        @(negedge clock);
        rd  = bus_if.cpu_read_data;
        hit = bus_if.cpu_read_hit;
        bus_if.cpu_address = 16'h0000;
    endtask

    task automatic burst(input logic [7:0] first, input int n);
        bus_if.cpu_address      = 16'hFFFB;
        bus_if.cpu_write_enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus_if.cpu_write_data = {8'h5A, first + 8'(i)};
            @(negedge clock);
        end
        bus_if.cpu_write_enable = 1'b0;
        bus_if.cpu_address      = 16'h0000;
        bus_if.cpu_write_data   = 16'h0000;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (frames_rx < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check(tag, 64'(frames_rx), 64'(n));
    endtask

    // Serial monitor: decodes frames sampled at negedge, pops the scoreboard.
    initial begin : monitor
        int         idle;
        logic [39:0] s;
        logic [39:0] b;
        logic [7:0] byt;
        logic [7:0] want;
        bit         aborted;
        bit         ok;
        idle = 0;
        forever begin
            @(negedge clock);
            if (mon_abort || reset) begin
                idle = 0;
                continue;
            end
            if (tx !== 1'b0) begin
                idle++;
                continue;
            end
            s[0] = tx;
            b[0] = tx_busy;
            aborted = 1'b0;
            for (int c = 1; c < 40; c++) begin
                @(negedge clock);
                if (mon_abort) aborted = 1'b1;
                s[c] = tx;
                b[c] = tx_busy;
            end
            if (aborted) begin
                idle = 0;
                continue;
            end
            ok = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
            for (int i = 0; i < 8; i++) begin
                byt[i] = s[4 + 4*i];
                if (s[4 + 4*i +: 4] != {4{s[4 + 4*i]}}) ok = 1'b0;
            end
            check("frame_shape", 64'(ok), 64'(1));
            check("frame_busy", 64'(b), 64'h00FF_FFFF_FFFF);
            check("frame_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                want = sb.pop_front();
                check("frame_byte", 64'(byt), 64'(want));
            end
            gaps.push_back(idle);
            frames_rx++;
            @(negedge clock);
            if (!mon_abort) check("busy_after_stop", 64'(tx_busy), 64'(0));
            idle = (tx === 1'b1) ? 1 : 0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] rd;
        logic        hit;
        int          base;
        bit          all_high;

        reset                   = 1'b1;
        bus_if.cpu_address      = 16'h0000;
        bus_if.cpu_write_data   = 16'h0000;
        bus_if.cpu_write_enable = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", 64'(tx), 64'(1));
        check("rst_busy", 64'(tx_busy), 64'(0));
        check("rst_rdata", 64'(bus_if.cpu_read_data), 64'(0));
        check("rst_hit", 64'(bus_if.cpu_read_hit), 64'(0));
        reset = 1'b0;
        @(negedge clock);

        // 1: idle status
        bus_read(16'hFFFA, rd, hit);
        check("t1_status", 64'(rd), 64'h0002);
        check("t1_hit", 64'(hit), 64'(1));
        check("t1_tx", 64'(tx), 64'(1));

        // 2: single frame of 0xA5 and its latency
        sb.push_back(8'hA5);
        bus_write(16'hFFFB, 16'h12A5);
        check("t2_tx_at_k", 64'(tx), 64'(1));
        @(negedge clock);
        check("t2_tx_at_k1", 64'(tx), 64'(1));
        @(negedge clock);
        check("t2_tx_at_k2", 64'(tx), 64'(0));
        check("t2_busy_at_k2", 64'(tx_busy), 64'(1));
        wait_frames("t2_frames", 1, 200);
        repeat (3) @(negedge clock);
        bus_read(16'hFFFA, rd, hit);
        check("t2_status", 64'(rd), 64'h0002);

        // 3: ten back-to-back writes, last one overflows
        base = frames_rx;
        for (int i = 1; i <= 9; i++) sb.push_back(8'(i));
        burst(8'h01, 10);
        bus_read(16'hFFFA, rd, hit);
        check("t3_status", 64'(rd), 64'h008D);
        check("t3_hit", 64'(hit), 64'(1));

        // 4: clear sticky overflow
        bus_write(16'hFFFA, 16'h0008);
        bus_read(16'hFFFA, rd, hit);
        check("t4_status", 64'(rd), 64'h0085);

        wait_frames("t3_frames", base + 9, 1000);
        check("t3_sb_drained", 64'(sb.size()), 64'(0));
        if (gaps.size() >= 8) begin
            for (int j = gaps.size() - 8; j < gaps.size(); j++)
                check("t3_gap", 64'(gaps[j]), 64'(1));
        end
        repeat (5) @(negedge clock);
        bus_read(16'hFFFA, rd, hit);
        check("t3_status_end", 64'(rd), 64'h0002);

        // 5: unrelated address
        base = frames_rx;
        bus_write(16'h1234, 16'h00FF);
        bus_read(16'h1234, rd, hit);
        check("t5_rdata", 64'(rd), 64'(0));
        check("t5_hit", 64'(hit), 64'(0));
        bus_read(16'hFFFA, rd, hit);
        check("t5_status", 64'(rd), 64'h0002);
        repeat (60) @(negedge clock);
        check("t5_no_frame", 64'(frames_rx), 64'(base));

        // 6: reset during DATA bit 3 of the first of three queued bytes
        mon_abort = 1'b1;
        sb.delete();
        burst(8'h48, 3);
        repeat (16) @(negedge clock);
        check("t6_bit3", 64'(tx), 64'(1));
        check("t6_busy_pre", 64'(tx_busy), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        check("t6_tx_after_rst", 64'(tx), 64'(1));
        check("t6_busy_after_rst", 64'(tx_busy), 64'(0));
        reset = 1'b0;
        bus_read(16'hFFFA, rd, hit);
        check("t6_status", 64'(rd), 64'h0002);
        all_high = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (tx !== 1'b1 || tx_busy !== 1'b0) all_high = 1'b0;
        end
        check("t6_line_idle", 64'(all_high), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
